// File: rtl/voice_envelope_amp_pkg.sv
// Shared definitions for the per-voice ADSR envelope and amplitude scaler.
package voice_envelope_amp_pkg;

  localparam int SAMPLE_BITS_DEF  = 12;
  localparam int ENV_ACC_BITS_DEF = 16;
  localparam int ENV_BITS_DEF     = 8;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/voice_envelope_amp_scaler.sv
// Two-stage signed sample x unsigned envelope multiply with arithmetic floor shift.
module envelope_scaler #(
  parameter int SAMPLE_BITS = 12,
  parameter int ENV_BITS    = 8
) (
  input  logic                          main_clk,
  input  logic                          rst,
  input  logic                          sample_en,
  input  logic signed [SAMPLE_BITS-1:0] din,
  input  logic        [ENV_BITS-1:0]    env,
  output logic signed [SAMPLE_BITS-1:0] dout,
  output logic                          dout_valid
);

  localparam int PW = SAMPLE_BITS + ENV_BITS;

  logic signed [SAMPLE_BITS-1:0] din_s1;
  logic        [ENV_BITS-1:0]    env_s1;
  logic                          valid_s1;
  logic signed [PW-1:0]          din_ext;
  logic signed [PW-1:0]          env_ext;
  logic signed [PW-1:0]          product;

  // |din * env| < 2^(PW-1), so a PW-bit product is exact and dout cannot overflow.
  assign din_ext = {{ENV_BITS{din_s1[SAMPLE_BITS-1]}}, din_s1};
  assign env_ext = {{SAMPLE_BITS{1'b0}}, env_s1};
  assign product = din_ext * env_ext;

  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      din_s1     <= '0;
      env_s1     <= '0;
      valid_s1   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      valid_s1   <= sample_en;
      dout_valid <= valid_s1;
      if (sample_en) begin
        din_s1 <= din;
        env_s1 <= env;
      end
      if (valid_s1) begin
        dout <= SAMPLE_BITS'(product >>> ENV_BITS);
      end
    end
  end

endmodule

// File: rtl/voice_envelope_amp.sv
// Gate-driven ADSR envelope generator feeding a 2-cycle amplitude scaler.
// dout_valid: single-cycle pulse, no backpressure; dout holds until the next pulse.
module voice_envelope_amp
  import voice_envelope_amp_pkg::*;
#(
  parameter int SAMPLE_BITS  = SAMPLE_BITS_DEF,
  parameter int ENV_ACC_BITS = ENV_ACC_BITS_DEF,
  parameter int ENV_BITS     = ENV_BITS_DEF
) (
  input  logic                           main_clk,
  input  logic                           rst,
  input  logic                           sample_en,
  input  logic                           gate,
  input  logic        [ENV_ACC_BITS-1:0] attack_inc,
  input  logic        [ENV_ACC_BITS-1:0] decay_inc,
  input  logic        [ENV_ACC_BITS-1:0] release_inc,
  input  logic        [ENV_BITS-1:0]     sustain_level,
  input  logic signed [SAMPLE_BITS-1:0]  din,
  output logic signed [SAMPLE_BITS-1:0]  dout,
  output logic                           dout_valid,
  output logic        [ENV_BITS-1:0]     env_level,
  output logic        [2:0]              env_state,
  output logic                           busy
);

  localparam logic [ENV_ACC_BITS-1:0] ACC_MAX = '1;

  env_state_e              state, state_nxt;
  logic [ENV_ACC_BITS-1:0] acc, acc_nxt;
  logic                    gate_q;
  logic                    rise, fall, upd;
  logic [ENV_ACC_BITS-1:0] thr;
  logic [ENV_ACC_BITS:0]   att_sum;
  logic [ENV_ACC_BITS:0]   dec_diff;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;
  // Any gate edge, even an ignored fall, suppresses the accumulator update.
  assign upd  = sample_en & ~rise & ~fall;

  assign thr      = ENV_ACC_BITS'(sustain_level) << (ENV_ACC_BITS - ENV_BITS);
  assign att_sum  = {1'b0, acc} + {1'b0, attack_inc};
  assign dec_diff = {1'b0, acc} - {1'b0, decay_inc};

  always_ff @(posedge main_clk or negedge rst) begin
    if (!rst) begin
      state  <= ENV_IDLE;
      acc    <= '0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      gate_q <= gate;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    if (rise) begin
      state_nxt = ENV_ATTACK;
    end else begin
      case (state)
        ENV_IDLE: begin
          if (upd) acc_nxt = '0;
        end
        ENV_ATTACK: begin
          if (fall) begin
            state_nxt = ENV_RELEASE;
          end else if (upd) begin
            if (att_sum[ENV_ACC_BITS] || (att_sum[ENV_ACC_BITS-1:0] == ACC_MAX)) begin
              acc_nxt   = ACC_MAX;
              state_nxt = ENV_DECAY;
            end else begin
              acc_nxt = att_sum[ENV_ACC_BITS-1:0];
            end
          end
        end
        ENV_DECAY: begin
          if (fall) begin
            state_nxt = ENV_RELEASE;
          end else if (upd) begin
            // Borrow out of the subtraction means we fell below zero, hence below thr.
            if (dec_diff[ENV_ACC_BITS] || (dec_diff[ENV_ACC_BITS-1:0] <= thr)) begin
              acc_nxt   = thr;
              state_nxt = ENV_SUSTAIN;
            end else begin
              acc_nxt = dec_diff[ENV_ACC_BITS-1:0];
            end
          end
        end
        ENV_SUSTAIN: begin
          if (fall) begin
            state_nxt = ENV_RELEASE;
          end else if (upd) begin
            acc_nxt = thr;
          end
        end
        ENV_RELEASE: begin
          if (upd) begin
            if (release_inc >= acc) begin
              acc_nxt   = '0;
              state_nxt = ENV_IDLE;
            end else begin
              acc_nxt = acc - release_inc;
            end
          end
        end
        default: state_nxt = ENV_IDLE;
      endcase
    end
  end

  assign env_level = acc[ENV_ACC_BITS-1 -: ENV_BITS];
  assign env_state = state;
  assign busy      = (state != ENV_IDLE);

  envelope_scaler #(
    .SAMPLE_BITS(SAMPLE_BITS),
    .ENV_BITS   (ENV_BITS)
  ) u_scaler (
    .main_clk  (main_clk),
    .rst       (rst),
    .sample_en (sample_en),
    .din       (din),
    .env       (env_level),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

endmodule

// File: tb/tb_voice_envelope_amp.sv
// Directed bench for voice_envelope_amp: ADSR walk-through with a dout scoreboard.
module tb_voice_envelope_amp;
  import voice_envelope_amp_pkg::*;

  localparam int SB = 12;
  localparam int AB = 16;
  localparam int EB = 8;

  logic                 main_clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 sample_en = 1'b0;
  logic                 gate = 1'b0;
  logic        [AB-1:0] attack_inc = '0;
  logic        [AB-1:0] decay_inc = '0;
  logic        [AB-1:0] release_inc = '0;
  logic        [EB-1:0] sustain_level = '0;
  logic signed [SB-1:0] din = '0;
  logic signed [SB-1:0] dout;
  logic                 dout_valid;
  logic        [EB-1:0] env_level;
  logic        [2:0]    env_state;
  logic                 busy;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [SB-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [SB-1:0] mon_e;
  int            mon_c;

  voice_envelope_amp dut (
    .main_clk     (main_clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .gate         (gate),
    .attack_inc   (attack_inc),
    .decay_inc    (decay_inc),
    .release_inc  (release_inc),
    .sustain_level(sustain_level),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .env_level    (env_level),
    .env_state    (env_state),
    .busy         (busy)
  );

  // Clock / cycle counter
  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  function automatic int scale(input int d, input int e);
    int p;
    p = d * e;
    return p >>> 8;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge main_clk);
  endtask

  // Driver: one sample_en pulse; back-to-back calls keep sample_en high every cycle.
  task automatic do_sample(input int d, input int exp_dout);
    exp_q.push_back(SB'(exp_dout));
    exp_cyc_q.push_back(cyc + 2);
    din       = SB'(d);
    sample_en = 1'b1;
    @(negedge main_clk);
    sample_en = 1'b0;
  endtask

  // Scoreboard monitor: value and 2-cycle latency of every dout_valid pulse.
  always @(negedge main_clk) begin
    if (dout_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL dout_valid: unexpected pulse, dout=%0d at cycle %0d", $signed(dout), cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (dout !== mon_e || cyc != mon_c) begin
          n_fail++;
          $display("FAIL dout: got %0d at cycle %0d, expected %0d at cycle %0d",
                   $signed(dout), cyc, $signed(mon_e), mon_c);
        end
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      n_checks++;
      n_fail++;
      mon_e = exp_q.pop_front();
      mon_c = exp_cyc_q.pop_front();
      $display("FAIL dout_valid: no pulse by cycle %0d, expected %0d at cycle %0d",
               cyc, $signed(mon_e), mon_c);
    end
  end

  initial begin
    din = 12'sd1000;
    repeat (3) step();
    check("reset_state", env_state, 0);
    check("reset_env", env_level, 0);
    check("reset_dout", dout, 0);
    check("reset_valid", dout_valid, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;

    // Idle: samples still flow through the scaler at env 0
    repeat (3) do_sample(1000, 0);
    step(); step();
    check("idle_state", env_state, 0);
    check("idle_env", env_level, 0);

    // Attack, back-to-back samples
    attack_inc = 16'h1000;
    gate = 1'b1;
    step();
    check("attack_enter_state", env_state, 1);
    check("attack_enter_env", env_level, 0);
    check("attack_busy", busy, 1);
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 1) do_sample(-777, scale(-777, i * 16));
      else            do_sample(1000, scale(1000, i * 16));
    end
    check("attack_15_env", env_level, 8'hF0);
    check("attack_15_state", env_state, 1);
    do_sample(1000, scale(1000, 8'hF0));
    check("attack_sat_env", env_level, 8'hFF);
    check("attack_sat_state", env_state, 2);

    // Decay to sustain 0x80
    decay_inc = 16'h0800;
    sustain_level = 8'h80;
    for (int k = 0; k < 15; k++) do_sample(500, scale(500, 255 - 8 * k));
    check("decay_15_env", env_level, 8'h87);
    check("decay_15_state", env_state, 2);
    do_sample(1000, scale(1000, 8'h87));
    check("decay_clamp_env", env_level, 8'h80);
    check("decay_clamp_state", env_state, 3);
    do_sample(1000, 500);
    check("sustain_env", env_level, 8'h80);
    sustain_level = 8'h40;
    do_sample(1000, 500);
    check("sustain_follow_env", env_level, 8'h40);
    check("sustain_follow_state", env_state, 3);
    sustain_level = 8'h80;
    do_sample(1000, 250);
    check("sustain_back_env", env_level, 8'h80);

    // Release to idle
    release_inc = 16'h4000;
    gate = 1'b0;
    step();
    check("release_enter_state", env_state, 4);
    check("release_enter_env", env_level, 8'h80);
    do_sample(-1000, -500);
    check("release_1_env", env_level, 8'h40);
    check("release_1_state", env_state, 4);
    do_sample(-1000, -250);
    check("release_2_env", env_level, 0);
    check("release_2_state", env_state, 0);
    check("release_2_busy", busy, 0);

    // Build RELEASE at 0x4000, then retrigger coincident with sample_en
    attack_inc = 16'h8000;
    gate = 1'b1;
    step();
    check("retrig_prep_state", env_state, 1);
    do_sample(300, 0);
    check("retrig_prep_env", env_level, 8'h80);
    gate = 1'b0;
    step();
    check("retrig_rel_state", env_state, 4);
    do_sample(300, 150);
    check("retrig_rel_env", env_level, 8'h40);
    attack_inc = 16'h1000;
    gate = 1'b1;
    do_sample(1000, 250);
    check("retrig_state", env_state, 1);
    check("retrig_env_held", env_level, 8'h40);
    do_sample(1000, 250);
    check("retrig_continue_env", env_level, 8'h50);

    // Attack overflow saturates; full-scale scaling with zero decay stall
    attack_inc = 16'hFFFF;
    decay_inc = 16'h0000;
    do_sample(1000, 312);
    check("ovf_env", env_level, 8'hFF);
    check("ovf_state", env_state, 2);
    do_sample(-2048, -2040);
    do_sample(2047, 2039);
    check("stall_env", env_level, 8'hFF);
    check("stall_state", env_state, 2);
    step(); step(); step();
    check("dout_hold", dout, 2039);
    check("dout_valid_low", dout_valid, 0);

    // Asynchronous reset mid-ATTACK
    gate = 1'b0;
    step();
    gate = 1'b1;
    step();
    check("pre_rst_state", env_state, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", env_state, 0);
    check("async_rst_env", env_level, 0);
    check("async_rst_dout", dout, 0);
    check("async_rst_valid", dout_valid, 0);
    check("async_rst_busy", busy, 0);
    step();
    rst = 1'b1;
    step();
    check("gate_high_at_release_state", env_state, 1);
    check("gate_high_at_release_env", env_level, 0);

    repeat (4) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_envelope_amp.md
Name: voice_envelope_amp

Overview:
- Per-voice ADSR envelope generator and amplitude scaler, placed directly downstream of a tone generator.
- Takes the tone generator's signed sample output, runs a gate-driven ADSR state machine, and multiplies each sample by the current envelope level.
- Output feeds the voice mixer.
- Single clock domain; sample-rate work is paced by a one-cycle strobe.

Parameters:
SAMPLE_BITS, 12, width of signed din/dout samples
ENV_ACC_BITS, 16, width of envelope accumulator and rate increments
ENV_BITS, 8, envelope level width (top ENV_BITS of accumulator)

Ports:
main_clk  in  1  system clock; all logic on posedge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
sample_en  in  1  one-main_clk-cycle strobe per audio sample
gate  in  1  note on (1) / off (0); sampled every main_clk
attack_inc  in  ENV_ACC_BITS  per-sample accumulator increment in ATTACK
decay_inc  in  ENV_ACC_BITS  per-sample decrement in DECAY
release_inc  in  ENV_ACC_BITS  per-sample decrement in RELEASE
sustain_level  in  ENV_BITS  sustain level
din  in  SAMPLE_BITS signed  tone generator sample
dout  out  SAMPLE_BITS signed  scaled sample
dout_valid  out  1  one-cycle pulse when dout updates
env_level  out  ENV_BITS  acc[ENV_ACC_BITS-1 -: ENV_BITS]
env_state  out  3  current state encoding
busy  out  1  env_state != IDLE

Behaviour:
- Reset (rst=0, async) sets: acc=0, state=IDLE, gate_q=0, pipeline regs=0, dout=0, dout_valid=0. If gate is held high through reset release, that counts as a rising edge and enters ATTACK.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5-7 are illegal and go to IDLE on the next clock.
- Edge detect uses gate_q registered every main_clk. rise = gate & ~gate_q; fall = ~gate & gate_q.
- rise, any state: go to ATTACK. acc is kept (no restart from zero, no click).
- fall, in ATTACK/DECAY/SUSTAIN: go to RELEASE. Ignored in IDLE/RELEASE.
- A gate edge takes priority over sample_en in the same cycle: the transition happens and acc is not updated that cycle.
- acc updates only on sample_en cycles that have no gate edge:
  - ATTACK: acc = min(acc+attack_inc, 2^ENV_ACC_BITS-1), computed with a carry bit. Reaching the max moves to DECAY in the same update.
  - DECAY: thr = sustain_level << (ENV_ACC_BITS-ENV_BITS). If acc-decay_inc <= thr (including underflow), acc=thr and go to SUSTAIN; else acc -= decay_inc.
  - SUSTAIN: acc = thr every sample, so sustain_level changes are followed.
  - RELEASE: if release_inc >= acc, acc=0 and go to IDLE; else acc -= release_inc.
  - IDLE: acc held at 0.
- A zero increment stalls the current stage indefinitely; this is legal and not an error.
- Scaler pipeline, latency 2 main_clk from sample_en:
  - Stage 1 (sample_en cycle): capture din and the pre-update env_level.
  - Stage 2: product = din * signed({1'b0, env}), dout = product[SAMPLE_BITS+ENV_BITS-1:ENV_BITS] (arithmetic floor shift), dout_valid=1.
- Full scale 0xFF gives din*255/256. dout never overflows.
- Back-to-back sample_en on every cycle is supported: the pipeline accepts one sample per cycle.

Decomposition:
- Shared package: state encodings (ENV_IDLE..ENV_RELEASE), default widths.
- Sub-module envelope_scaler: 2-stage signed multiply/shift with valid pipeline, parameters SAMPLE_BITS and ENV_BITS.
- FSM and accumulator stay in the top module.

Test Plan:
1. Reset with gate=0, din=1000, sample_en pulses -> env_state=0, env_level=0, dout=0, dout_valid 2 cycles after each sample_en.
2. gate rise, attack_inc=0x1000 -> ATTACK; acc 0x1000..0xF000 after 15 samples; 16th saturates at 0xFFFF, env_level=0xFF, state DECAY.
3. decay_inc=0x0800, sustain_level=0x80 from 0xFFFF -> 16th sample clamps acc=0x8000, SUSTAIN. din=1000 -> dout=500. Then change sustain_level to 0x40 -> acc=0x4000 on next sample.
4. In SUSTAIN at 0x8000, gate fall, release_inc=0x4000 -> RELEASE; 0x4000, then 0x0000 and IDLE on 2nd sample; busy drops.
5. Retrigger in RELEASE at acc=0x4000 -> ATTACK continues from env_level 0x40; gate rise coincident with sample_en -> acc unchanged that cycle.
6. Full-scale scaling at env=0xFF -> din=-2048 gives dout=-2040, din=2047 gives dout=2039. Assert rst mid-ATTACK -> all outputs 0 immediately (async).
